// File: rtl/rf_write_arbiter.sv
// Purpose: round-robin share of the single register-file write port among ALU, load and stack requesters.
// Latency: one cycle from an uncontended request to its gnt pulse and the matching WrEn write.
// Backpressure: requests are held until their gnt; a losing requester waits at most three cycles.
module rf_write_arbiter #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int ADDR     = 2,
  parameter int SP_ADDR  = 3,
  parameter int SP_RESET = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             alu_req,
  input  logic [ADDR-1:0]  alu_addr,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_gnt,
  input  logic             ld_req,
  input  logic [ADDR-1:0]  ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_gnt,
  input  logic             sp_push,
  input  logic             sp_pop,
  output logic             sp_gnt,
  output logic             WrEn,
  output logic [ADDR-1:0]  W_Add,
  output logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] Sp,
  output logic [DEPTH-1:0] pend
);

  localparam logic [ADDR-1:0]  SP_A   = ADDR'(SP_ADDR);
  localparam logic [WIDTH-1:0] SP_RST = WIDTH'(SP_RESET);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  // Requester indices: 0 = ALU, 1 = load, 2 = stack engine.
  localparam logic [1:0] IDX_ALU = 2'd0;
  localparam logic [1:0] IDX_LD  = 2'd1;
  localparam logic [1:0] IDX_SP  = 2'd2;

  logic             alu_gnt_q, alu_gnt_d;
  logic             ld_gnt_q,  ld_gnt_d;
  logic             sp_gnt_q,  sp_gnt_d;
  logic             wr_en_q,   wr_en_d;
  logic [ADDR-1:0]  w_add_q,   w_add_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [WIDTH-1:0] sp_q,      sp_d;
  logic [1:0]       last_q,    last_d;

  logic             sp_req;
  logic             alu_elig, ld_elig, sp_elig;
  logic [2:0]       elig;
  logic             win_vld;
  logic [1:0]       win_idx;
  logic [DEPTH-1:0] pend_v;

  // A requester is masked in its own grant cycle so a still-visible request is not issued twice.
  always_comb begin
    sp_req   = sp_push | sp_pop;
    alu_elig = alu_req & ~alu_gnt_q;
    ld_elig  = ld_req  & ~ld_gnt_q;
    sp_elig  = sp_req  & ~sp_gnt_q;
    elig     = {sp_elig, ld_elig, alu_elig};
  end

  // Round-robin search starting just after the last winner, wrapping over the three requesters.
  always_comb begin
    win_vld = 1'b0;
    win_idx = IDX_ALU;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (int'(last_q) + 1 + k) % 3;
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win_idx = 2'(idx);
      end
    end
  end

  // Next-state for grants and the write port; the port holds its address/data when idle.
  always_comb begin
    alu_gnt_d = 1'b0;
    ld_gnt_d  = 1'b0;
    sp_gnt_d  = 1'b0;
    wr_en_d   = 1'b0;
    w_add_d   = w_add_q;
    wr_data_d = wr_data_q;
    last_d    = last_q;
    sp_d      = sp_q;
    if (win_vld) begin
      last_d = win_idx;
      case (win_idx)
        IDX_ALU: begin
          alu_gnt_d = 1'b1;
          wr_en_d   = 1'b1;
          w_add_d   = alu_addr;
          wr_data_d = alu_data;
        end
        IDX_LD: begin
          ld_gnt_d  = 1'b1;
          wr_en_d   = 1'b1;
          w_add_d   = ld_addr;
          wr_data_d = ld_data;
        end
        default: begin
          // Push and pop together cancel: acknowledge but write nothing.
          sp_gnt_d = 1'b1;
          if (sp_push ^ sp_pop) begin
            wr_en_d   = 1'b1;
            w_add_d   = SP_A;
            wr_data_d = sp_push ? (sp_q - ONE) : (sp_q + ONE);
          end
        end
      endcase
    end
    // The shadow SP follows every write to the SP register, whichever requester made it.
    if (wr_en_d && (w_add_d == SP_A)) begin
      sp_d = wr_data_d;
    end
  end

  // Pending-write vector for hazard logic: only requests not yet granted count.
  always_comb begin
    pend_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_elig && (int'(alu_addr) == i)) pend_v[i] = 1'b1;
      if (ld_elig  && (int'(ld_addr)  == i)) pend_v[i] = 1'b1;
    end
    if (sp_elig) pend_v[SP_ADDR] = 1'b1;
  end

  // Issue register: grants, write port, shadow SP and round-robin pointer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_gnt_q <= 1'b0;
      ld_gnt_q  <= 1'b0;
      sp_gnt_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      w_add_q   <= '0;
      wr_data_q <= '0;
      sp_q      <= SP_RST;
      last_q    <= IDX_SP;
    end else begin
      alu_gnt_q <= alu_gnt_d;
      ld_gnt_q  <= ld_gnt_d;
      sp_gnt_q  <= sp_gnt_d;
      wr_en_q   <= wr_en_d;
      w_add_q   <= w_add_d;
      wr_data_q <= wr_data_d;
      sp_q      <= sp_d;
      last_q    <= last_d;
    end
  end

  assign alu_gnt = alu_gnt_q;
  assign ld_gnt  = ld_gnt_q;
  assign sp_gnt  = sp_gnt_q;
  assign WrEn    = wr_en_q;
  assign W_Add   = w_add_q;
  assign WrData  = wr_data_q;
  assign Sp      = sp_q;
  assign pend    = pend_v;

endmodule
